// File: rtl/pktctrl_pkg.sv
// pktctrl_pkg: constants, scheduler state encoding and small helpers shared by the
// pktctrl read-side scheduler and the round-robin arbiter.
//   NUM_CH   - number of requesting capture buffers
//   WORD_W   - buffer word width (two pad beats)
//   BEAT_W   - pad bus width
//   CH_W     - channel index width
//   HDR_MARK - marker bit leading the optional burst header beat
package pktctrl_pkg;

    localparam int NUM_CH = 24;
    localparam int WORD_W = 36;
    localparam int BEAT_W = 18;
    localparam int CH_W   = 5;

    localparam logic HDR_MARK = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        HDR  = 3'd2,
        LO   = 3'd3,
        HI   = 3'd4,
        GAP  = 3'd5
    } sched_state_e;

    // One-hot pop strobe for a channel index.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

    // Burst header beat: marker, spare zeros, channel, programmed length.
    function automatic logic [BEAT_W-1:0] hdr_beat(input logic [CH_W-1:0] ch,
                                                   input logic [7:0]      len);
        return {HDR_MARK, 4'b0000, ch, len};
    endfunction

endpackage

// File: rtl/pktctrl_rr_arb.sv
// pktctrl_rr_arb: combinational rotate-priority encoder.
//   req     in  NUM_CH  request vector (already masked by the caller)
//   last_ch in  CH_W    previously granted channel; search starts at last_ch+1
//   gnt_vld out 1       some request is set
//   gnt_ch  out CH_W    first requesting channel after last_ch, with wrap
module pktctrl_rr_arb
    import pktctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_ch,
    output logic              gnt_vld,
    output logic [CH_W-1:0]   gnt_ch
);

    // Walk the channels starting just after last_ch; the first hit wins and
    // later hits are ignored, so last_ch itself has the lowest priority.
    always_comb begin
        int  idx;
        logic hit;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = 0;
        hit     = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx     = (int'(last_ch) + k) % NUM_CH;
            hit     = !gnt_vld && req[idx];
            gnt_ch  = hit ? CH_W'(idx) : gnt_ch;
            gnt_vld = gnt_vld | hit;
        end
    end

endmodule

// File: rtl/pktctrl_sched.sv
// pktctrl_sched: read-side burst scheduler (pktctrl_rclk domain).
// Round-robin grants one capture buffer at a time, pops rf_burst_len words from it
// and sends each 36-bit word as two 18-bit pad beats (low half first).
//   pktctrl_rclk/pktctrl_rrst  clock, asynchronous active-high reset
//   rf_sched_en, rf_chan_en    global enable, per-channel enable mask
//   rf_burst_len               words per grant, 0 means 256 (sampled at grant)
//   ch_req, ch_rdata           per-channel request, FWFT head words
//   ch_rd                      one-hot pop strobe
//   adc_data, adc_data_valid   pad beat bus
//   sched_busy, sched_cur_ch   status
// Optional build macro PKTCTRL_SCHED_HDR_EN inserts one header beat per burst.
module pktctrl_sched
    import pktctrl_pkg::*;
(
    input  logic                     pktctrl_rclk,
    input  logic                     pktctrl_rrst,
    input  logic                     rf_sched_en,
    input  logic [NUM_CH-1:0]        rf_chan_en,
    input  logic [7:0]               rf_burst_len,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*WORD_W-1:0] ch_rdata,
    output logic [NUM_CH-1:0]        ch_rd,
    output logic [BEAT_W-1:0]        adc_data,
    output logic                     adc_data_valid,
    output logic                     sched_busy,
    output logic [CH_W-1:0]          sched_cur_ch
);

    sched_state_e      state_q, state_d;
    logic [CH_W-1:0]   gnt_ch_q, gnt_ch_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [8:0]        wcnt_q, wcnt_d;
    logic [BEAT_W-1:0] word_hi_q, word_hi_d;
    logic [BEAT_W-1:0] adc_data_q, adc_data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [NUM_CH-1:0] ch_rd_q, ch_rd_d;
`ifdef PKTCTRL_SCHED_HDR_EN
    logic [7:0]        len_q, len_d;
`endif

    logic [NUM_CH-1:0] req_m;
    logic              arb_vld;
    logic [CH_W-1:0]   arb_ch;
    logic [WORD_W-1:0] rdata_arr [NUM_CH];
    logic [WORD_W-1:0] head_word;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign rdata_arr[gi] = ch_rdata[gi*WORD_W +: WORD_W];
    end

    assign head_word = rdata_arr[gnt_ch_q];
    assign req_m     = ch_req & rf_chan_en;

    pktctrl_rr_arb u_arb (
        .req     (req_m),
        .last_ch (last_ch_q),
        .gnt_vld (arb_vld),
        .gnt_ch  (arb_ch)
    );

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        gnt_ch_d   = gnt_ch_q;
        last_ch_d  = last_ch_q;
        cur_ch_d   = cur_ch_q;
        wcnt_d     = wcnt_q;
        word_hi_d  = word_hi_q;
        adc_data_d = adc_data_q;
        valid_d    = 1'b0;
`ifdef PKTCTRL_SCHED_HDR_EN
        len_d      = len_q;
`endif
        case (state_q)
            IDLE: begin
                if (rf_sched_en && (|req_m)) begin
                    state_d = ARB;
                end else begin
                    state_d = IDLE;
                end
            end
            ARB: begin
                // Requests may vanish between IDLE and ARB; fall back quietly.
                if (arb_vld) begin
                    gnt_ch_d  = arb_ch;
                    last_ch_d = arb_ch;
                    cur_ch_d  = arb_ch;
                    wcnt_d    = (rf_burst_len == 8'd0) ? 9'd256 : {1'b0, rf_burst_len};
`ifdef PKTCTRL_SCHED_HDR_EN
                    len_d     = rf_burst_len;
                    state_d   = HDR;
`else
                    state_d   = LO;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef PKTCTRL_SCHED_HDR_EN
            HDR: begin
                adc_data_d = hdr_beat(gnt_ch_q, len_q);
                valid_d    = 1'b1;
                state_d    = LO;
            end
`endif
            LO: begin
                // The pop and the capture share this edge, so the FWFT head is still
                // the word being popped.
                word_hi_d  = head_word[WORD_W-1:BEAT_W];
                adc_data_d = head_word[BEAT_W-1:0];
                valid_d    = 1'b1;
                state_d    = HI;
            end
            HI: begin
                adc_data_d = word_hi_q;
                valid_d    = 1'b1;
                wcnt_d     = wcnt_q - 9'd1;
                if (wcnt_q == 9'd1) begin
                    state_d = GAP;
                end else begin
                    state_d = LO;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Pop strobe is registered, so raise it for the cycle spent in LO.
        ch_rd_d = (state_d == LO) ? ch_onehot(gnt_ch_d) : '0;
        busy_d  = (state_d != IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge pktctrl_rclk or posedge pktctrl_rrst) begin
        if (pktctrl_rrst) begin
            state_q    <= IDLE;
            gnt_ch_q   <= '0;
            last_ch_q  <= CH_W'(NUM_CH - 1);
            cur_ch_q   <= '0;
            wcnt_q     <= 9'd0;
            word_hi_q  <= '0;
            adc_data_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ch_rd_q    <= '0;
`ifdef PKTCTRL_SCHED_HDR_EN
            len_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_ch_q   <= gnt_ch_d;
            last_ch_q  <= last_ch_d;
            cur_ch_q   <= cur_ch_d;
            wcnt_q     <= wcnt_d;
            word_hi_q  <= word_hi_d;
            adc_data_q <= adc_data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ch_rd_q    <= ch_rd_d;
`ifdef PKTCTRL_SCHED_HDR_EN
            len_q      <= len_d;
`endif
        end
    end

    assign ch_rd          = ch_rd_q;
    assign adc_data       = adc_data_q;
    assign adc_data_valid = valid_q;
    assign sched_busy     = busy_q;
    assign sched_cur_ch   = cur_ch_q;

endmodule

// File: tb/tb_pktctrl_sched.sv
// tb_pktctrl_sched: self-checking bench for pktctrl_sched.
// A transaction-level model turns each grant into the expected per-cycle output
// stream and is compared with the DUT every cycle; directed segments add literal
// expectations (beat values, grant order, pulse and beat counts).
// Honours PKTCTRL_SCHED_HDR_EN the same way the design does.
module tb_pktctrl_sched;
    import pktctrl_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     en;
    logic [NUM_CH-1:0]        mask;
    logic [7:0]               len;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*WORD_W-1:0] ch_rdata;
    logic [NUM_CH-1:0]        ch_rd;
    logic [BEAT_W-1:0]        adc_data;
    logic                     adc_valid;
    logic                     busy;
    logic [CH_W-1:0]          cur_ch;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pktctrl_sched dut (
        .pktctrl_rclk   (clk),
        .pktctrl_rrst   (rst),
        .rf_sched_en    (en),
        .rf_chan_en     (mask),
        .rf_burst_len   (len),
        .ch_req         (req),
        .ch_rdata       (ch_rdata),
        .ch_rd          (ch_rd),
        .adc_data       (adc_data),
        .adc_data_valid (adc_valid),
        .sched_busy     (busy),
        .sched_cur_ch   (cur_ch)
    );

    // ---------------- buffer sources (FWFT, never run dry) ----------------
    logic [WORD_W-1:0] wbase [NUM_CH];
    int                src_cnt [NUM_CH] = '{default: 0};

    function automatic logic [WORD_W-1:0] word_at(input int ch, input int n);
        logic [WORD_W-1:0] nn;
        nn = 36'(n);
        return wbase[ch] + nn * 36'h0_0001_0203;
    endfunction

    always_comb begin
        ch_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) ch_rdata[i*WORD_W +: WORD_W] = word_at(i, src_cnt[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) if (ch_rd[i]) src_cnt[i] <= src_cnt[i] + 1;
    end

    // ---------------- transaction model ----------------
    typedef struct packed {
        logic              vld;
        logic [BEAT_W-1:0] data;
        logic [NUM_CH-1:0] rd;
        logic              busy;
        logic [CH_W-1:0]   cur;
    } exp_t;

    exp_t              expq [$];
    int                m_cnt [NUM_CH] = '{default: 0};
    int                m_last = NUM_CH - 1;
    logic              m_arb  = 1'b0;
    logic [BEAT_W-1:0] m_data = '0;
    logic [CH_W-1:0]   m_cur  = '0;

    function automatic exp_t mk(input logic v, input logic [BEAT_W-1:0] d,
                                input logic [NUM_CH-1:0] r, input logic b,
                                input logic [CH_W-1:0] c);
        exp_t e;
        e.vld = v; e.data = d; e.rd = r; e.busy = b; e.cur = c;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            // Pops that were predicted but never reached are given back.
            foreach (expq[j]) for (int c = 0; c < NUM_CH; c++) if (expq[j].rd[c]) m_cnt[c]--;
            expq.delete();
            m_arb  = 1'b0;
            m_last = NUM_CH - 1;
            m_data = '0;
            m_cur  = '0;
        end else if (m_arb) begin
            int g;
            logic [NUM_CH-1:0] rq;
            m_arb = 1'b0;
            rq = req & mask;
            g  = -1;
            for (int k = 1; k <= NUM_CH && g < 0; k++) if (rq[(m_last + k) % NUM_CH]) g = (m_last + k) % NUM_CH;
            if (g >= 0) begin
                int L;
                logic              pv;
                logic [BEAT_W-1:0] pd;
                logic [NUM_CH-1:0] oh;
                logic [WORD_W-1:0] w;
                L  = (len == 8'd0) ? 256 : int'(len);
                oh = '0;
                oh[g] = 1'b1;
                pv = 1'b0;
                pd = m_data;
`ifdef PKTCTRL_SCHED_HDR_EN
                expq.push_back(mk(1'b0, pd, '0, 1'b1, 5'(g)));
                pv = 1'b1;
                pd = {1'b1, 4'b0000, 5'(g), len};
`endif
                for (int k = 0; k < L; k++) begin
                    w = word_at(g, m_cnt[g] + k);
                    expq.push_back(mk(pv, pd, oh, 1'b1, 5'(g)));
                    expq.push_back(mk(1'b1, w[BEAT_W-1:0], '0, 1'b1, 5'(g)));
                    pv = 1'b1;
                    pd = w[WORD_W-1:BEAT_W];
                end
                expq.push_back(mk(1'b1, pd, '0, 1'b1, 5'(g)));   // last high beat
                expq.push_back(mk(1'b0, pd, '0, 1'b0, 5'(g)));   // mandatory idle cycle
                m_cnt[g] += L;
                m_data = pd;
                m_cur  = 5'(g);
                m_last = g;
            end
        end else if (expq.size() == 0 && en && (|(req & mask))) begin
            expq.push_back(mk(1'b0, m_data, '0, 1'b1, m_cur));
            m_arb = 1'b1;
        end
    end

    // ---------------- compare process + logging ----------------
    logic [BEAT_W-1:0] beats [$];
    int                grants [$];
    int                rd_cnt [NUM_CH] = '{default: 0};
    logic              in_b = 1'b0;
    int                burst_ch = -1;

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (expq.size() > 0) e = expq.pop_front();
        else e = mk(1'b0, m_data, '0, 1'b0, m_cur);
        a = mk(adc_valid, adc_data, ch_rd, busy, cur_ch);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle t=%0t got vld=%0b data=%05h rd=%06h busy=%0b cur=%0d want vld=%0b data=%05h rd=%06h busy=%0b cur=%0d",
                     $time, a.vld, a.data, a.rd, a.busy, a.cur, e.vld, e.data, e.rd, e.busy, e.cur);
        end
        // Requester contract: a granted channel keeps requesting until its burst ends.
        if (!busy) burst_ch = -1;
        for (int i = 0; i < NUM_CH; i++) if (ch_rd[i]) burst_ch = i;
        if (burst_ch >= 0) begin
            checks++;
            if (!req[burst_ch]) begin
                errors++;
                $display("FAIL req_contract ch=%0d got req=0 want req=1", burst_ch);
            end
        end
        if (adc_valid) beats.push_back(adc_data);
        for (int i = 0; i < NUM_CH; i++) if (ch_rd[i]) begin
            rd_cnt[i]++;
            if (!in_b) grants.push_back(i);
            in_b = 1'b1;
        end
        if (!busy) in_b = 1'b0;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        beats.delete();
        grants.delete();
        for (int i = 0; i < NUM_CH; i++) rd_cnt[i] = 0;
    endtask

    // Returns at the negedge of the idle cycle that follows the n-th burst.
    task automatic wait_bursts(input int n, input int budget);
        int   done = 0;
        logic was  = 1'b0;
        for (int c = 0; c < budget && done < n; c++) begin
            @(negedge clk);
            if (busy) was = 1'b1;
            else if (was) begin
                was = 1'b0;
                done++;
            end
        end
        chk("wait_bursts", done, n);
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int c = 0; c < budget && beats.size() < n; c++) @(negedge clk);
        chk("wait_beats", beats.size(), n);
    endtask

    task automatic wait_pop(input int budget);
        logic seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            seen = (ch_rd != '0);
        end
        chk("wait_pop", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        en   = 1'b0;
        mask = '1;
        len  = 8'd1;
        req  = '0;
        for (int i = 0; i < NUM_CH; i++) wbase[i] = 36'h0_1357_9BDF * 36'(i + 1);
        wbase[0] = 36'h9_ABCD_1234;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", adc_valid, 0);
        chk("rst_data", adc_data, 0);
        chk("rst_rd", ch_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur", cur_ch, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Single word burst on channel 0.
        @(posedge clk);
        #2;
        clear_logs();
        en     = 1'b1;
        req[0] = 1'b1;
        wait_bursts(1, 40);
        req = '0;
        repeat (3) @(negedge clk);
        chk("t1_nbeats", beats.size(), 2);
        chk("t1_beat0", (beats.size() > 0) ? beats[0] : 18'h0, 18'h11234);
        chk("t1_beat1", (beats.size() > 1) ? beats[1] : 18'h0, 18'h26AF3);
        chk("t1_pops", rd_cnt[0], 1);

        // Round robin over channels 3, 7, 23.
        clear_logs();
        len = 8'd2;
        req[3] = 1'b1; req[7] = 1'b1; req[23] = 1'b1;
        wait_bursts(4, 100);
        req = '0;
        repeat (3) @(negedge clk);
        chk("rr_ngrants", grants.size(), 4);
        chk("rr_g0", (grants.size() > 0) ? grants[0] : -1, 3);
        chk("rr_g1", (grants.size() > 1) ? grants[1] : -1, 7);
        chk("rr_g2", (grants.size() > 2) ? grants[2] : -1, 23);
        chk("rr_g3", (grants.size() > 3) ? grants[3] : -1, 3);
        chk("rr_nbeats", beats.size(), 16);

        // Masked channel 7 never wins.
        clear_logs();
        len     = 8'd1;
        mask[7] = 1'b0;
        req[3] = 1'b1; req[7] = 1'b1;
        wait_bursts(3, 60);
        req = '0;
        repeat (2) @(negedge clk);
        mask = '1;
        chk("mask_pops7", rd_cnt[7], 0);
        chk("mask_pops3", rd_cnt[3], 3);

        // Enable dropped during beat 3 of a 4-word burst; length change ignored.
        clear_logs();
        len     = 8'd4;
        req[10] = 1'b1;
        wait_beats(3, 40);
        en  = 1'b0;
        len = 8'd1;
        wait_bursts(1, 40);
        repeat (4) @(negedge clk);
        chk("en_nbeats", beats.size(), 8);
        chk("en_ngrants", grants.size(), 1);
        chk("en_busy", busy, 0);
        req = '0;
        en  = 1'b1;
        repeat (2) @(negedge clk);

        // burst_len 0 means 256 words.
        clear_logs();
        len    = 8'd0;
        req[5] = 1'b1;
        wait_bursts(1, 1200);
        req = '0;
        repeat (2) @(negedge clk);
        chk("l0_pops", rd_cnt[5], 256);
        chk("l0_nbeats", beats.size(), 512);

        // Reset while in HI, then channel 0 wins first.
        len    = 8'd4;
        req[0] = 1'b1; req[9] = 1'b1;
        wait_pop(40);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", adc_valid, 0);
        chk("mrst_data", adc_data, 0);
        chk("mrst_rd", ch_rd, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_cur", cur_ch, 0);
        clear_logs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_bursts(1, 60);
        req = '0;
        repeat (2) @(negedge clk);
        chk("mrst_ngrants", grants.size(), 1);
        chk("mrst_first", (grants.size() > 0) ? grants[0] : -1, 0);

`ifdef PKTCTRL_SCHED_HDR_EN
        // Header beat precedes the data beats.
        clear_logs();
        len     = 8'd3;
        req[12] = 1'b1;
        wait_bursts(1, 60);
        req = '0;
        repeat (2) @(negedge clk);
        chk("hdr_nbeats", beats.size(), 7);
        chk("hdr_beat", (beats.size() > 0) ? beats[0] : 18'h0, 18'h20C03);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
